// File: rtl/mem_pkg.sv
// Shared types and helpers for the RAM responder: word width, request
// struct and the word-alignment check.
package mem_pkg;

  localparam int unsigned WORD_W        = 32;
  localparam int unsigned BYTE_OFFSET_W = 2;

  typedef logic [WORD_W-1:0] mem_word_t;

  typedef struct packed {
    logic             en;
    logic [WORD_W-1:0] addr;
    mem_word_t        data;
  } mem_req_t;

  function automatic logic is_aligned(input logic [WORD_W-1:0] addr);
    return addr[BYTE_OFFSET_W-1:0] == '0;
  endfunction

endpackage

// File: rtl/rd_latency_pipe.sv
// Shift register of {valid, data} that delays read results by STAGES cycles.
// Data in each stage only moves with a valid, so the output holds between reads.
module rd_latency_pipe
  import mem_pkg::*;
#(
  parameter int unsigned STAGES = 1
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      valid_i,
  input  mem_word_t data_i,
  output logic      valid_o,
  output mem_word_t data_o
);

  logic [STAGES-1:0] valid_q, valid_d;
  mem_word_t         data_q [STAGES];
  mem_word_t         data_d [STAGES];

  always_comb begin
    valid_d[0] = valid_i;
    data_d[0]  = valid_i ? data_i : data_q[0];
    for (int i = 1; i < STAGES; i++) begin
      valid_d[i] = valid_q[i-1];
      data_d[i]  = valid_q[i-1] ? data_q[i-1] : data_q[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      data_q  <= '{default: '0};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q[STAGES-1];
  assign data_o  = data_q[STAGES-1];

endmodule

// File: rtl/ram_responder.sv
// Word-organised RAM answering one read and one write per cycle, with a
// fixed read latency, write acknowledge and fault reporting for bad addresses.
module ram_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned RD_LATENCY  = 1,
  parameter bit          INIT_ZERO   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_ram_en,
  input  logic [WORD_W-1:0] rd_ram_addr,
  output mem_word_t         rd_ram_data,
  output logic              rd_ram_valid,
  input  logic              wr_ram_en,
  input  logic [WORD_W-1:0] wr_ram_addr,
  input  mem_word_t         wr_ram_data,
  output logic              wr_ram_ack,
  output logic              fault,
  output logic [WORD_W-1:0] fault_addr
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
  typedef logic [IdxW-1:0] idx_t;

  function automatic logic is_legal(input logic [WORD_W-1:0] addr);
    return is_aligned(addr) && ((addr >> (IdxW + BYTE_OFFSET_W)) == '0);
  endfunction

  mem_word_t mem_q [DEPTH_WORDS];

  mem_req_t          wr_req;
  logic              clear_busy_q, clear_busy_d;
  idx_t              clr_cnt_q, clr_cnt_d;
  logic              wr_ack_q, wr_ack_d;
  logic              fault_q, fault_d;
  logic [WORD_W-1:0] fault_addr_q, fault_addr_d;

  logic      rd_accept, rd_ok, rd_bad;
  logic      wr_ok, wr_bad;
  idx_t      rd_idx, wr_idx;
  mem_word_t rd_word;
  logic      mem_we;
  idx_t      mem_widx;
  mem_word_t mem_wdata;

  assign wr_req = '{en: wr_ram_en, addr: wr_ram_addr, data: wr_ram_data};

  assign rd_idx = rd_ram_addr[IdxW+BYTE_OFFSET_W-1:BYTE_OFFSET_W];
  assign wr_idx = wr_req.addr[IdxW+BYTE_OFFSET_W-1:BYTE_OFFSET_W];

  // Requests are ignored entirely while the post-reset clear is running.
  assign rd_accept = rd_ram_en && !clear_busy_q;
  assign rd_ok     = rd_accept && is_legal(rd_ram_addr);
  assign rd_bad    = rd_accept && !is_legal(rd_ram_addr);
  assign wr_ok     = wr_req.en && !clear_busy_q && is_legal(wr_req.addr);
  assign wr_bad    = wr_req.en && !clear_busy_q && !is_legal(wr_req.addr);

  // Array read happens before the same-edge write lands: read-before-write.
  assign rd_word = rd_ok ? mem_q[rd_idx] : '0;

  always_comb begin
    mem_we    = 1'b0;
    mem_widx  = wr_idx;
    mem_wdata = wr_req.data;
    if (clear_busy_q) begin
      mem_we    = 1'b1;
      mem_widx  = clr_cnt_q;
      mem_wdata = '0;
    end else if (wr_ok) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_widx] <= mem_wdata;
    end
  end

  always_comb begin
    clear_busy_d = clear_busy_q;
    clr_cnt_d    = clr_cnt_q;
    if (clear_busy_q) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == idx_t'(DEPTH_WORDS - 1)) begin
        clear_busy_d = 1'b0;
      end
    end
    wr_ack_d = wr_ok;
    fault_d  = rd_bad || wr_bad;
    // Write address wins when both sides fault in the same cycle.
    if (wr_bad) begin
      fault_addr_d = wr_req.addr;
    end else if (rd_bad) begin
      fault_addr_d = rd_ram_addr;
    end else begin
      fault_addr_d = fault_addr_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clear_busy_q <= INIT_ZERO;
      clr_cnt_q    <= '0;
      wr_ack_q     <= 1'b0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      clear_busy_q <= clear_busy_d;
      clr_cnt_q    <= clr_cnt_d;
      wr_ack_q     <= wr_ack_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  rd_latency_pipe #(
    .STAGES(RD_LATENCY)
  ) u_rd_pipe (
    .clk    (clk),
    .reset  (reset),
    .valid_i(rd_accept),
    .data_i (rd_word),
    .valid_o(rd_ram_valid),
    .data_o (rd_ram_data)
  );

  assign wr_ram_ack = wr_ack_q;
  assign fault      = fault_q;
  assign fault_addr = fault_addr_q;

endmodule

// File: doc/ram_responder.md
Name: ram_responder

Overview:
- Memory-side responder for the execution unit's RAM interface: the instruction-fetch read port (rd_ram_*) and the data write port (wr_ram_*).
- Holds a word-organised storage array and answers one read and one write per cycle.
- Read data returns after a fixed, parameterised pipeline latency, with a valid strobe.
- Used as the memory model beside exec_unit in simulation and as the on-chip RAM wrapper in synthesis.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words stored; power of two, >= 2
RD_LATENCY, 1, cycles from rd_ram_en sample to rd_ram_valid; legal range 1..4
INIT_ZERO, 1, 1 = storage contents also forced to 0 by reset; 0 = contents survive reset

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high reset
rd_ram_en  input  1  read request, sampled every rising edge
rd_ram_addr  input  32  byte address of the read
rd_ram_data  output  32  read data, meaningful only while rd_ram_valid=1
rd_ram_valid  output  1  read data strobe, one cycle per accepted read
wr_ram_en  input  1  write request, sampled every rising edge
wr_ram_addr  input  32  byte address of the write
wr_ram_data  input  32  write data
wr_ram_ack  output  1  one-cycle pulse, the cycle after a write commits
fault  output  1  one-cycle pulse on any misaligned or out-of-range request
fault_addr  output  32  address that caused the most recent fault; held until the next fault

Behaviour:
- Reset is asynchronous and active-high; one clock. While reset=1:
  - rd_ram_valid, wr_ram_ack and fault are 0.
  - rd_ram_data and fault_addr are 0.
  - All read-pipeline stages are invalidated; in-flight reads are dropped, never delivered.
  - If INIT_ZERO=1, every storage word is 0 after reset is released. The clear may take DEPTH_WORDS cycles, and during that time the responder ignores requests. A clear_busy internal flag gates acceptance; rd_ram_valid and wr_ram_ack stay 0.
- Addressing:
  - Word index is addr[log2(DEPTH_WORDS)+1:2].
  - A request is legal only if addr[1:0]==0 and addr < 4*DEPTH_WORDS.
- Read:
  - A legal rd_ram_en at edge N reads the array at edge N.
  - rd_ram_valid=1 with rd_ram_data appears at edge N+RD_LATENCY-1, i.e. visible during the cycle after edge N when RD_LATENCY=1.
  - Throughput is one read per cycle. Back-to-back reads return in request order with no gaps.
- Write:
  - A legal wr_ram_en at edge N updates the word at edge N.
  - wr_ram_ack=1 during the following cycle.
- Same-cycle read and write to the same word: the read returns the OLD contents (read-before-write). A read sampled at any later edge sees the new contents.
- Illegal request, read or write:
  - No array access: the write is dropped and no wr_ram_ack is given.
  - An illegal read still produces its rd_ram_valid slot with rd_ram_data=32'h0000_0000, so the fetch stream stays aligned.
  - fault pulses in the cycle after the sampling edge; fault_addr is updated.
- Simultaneous illegal read and illegal write: fault pulses once. fault_addr takes the write address (write has priority).
- rd_ram_data holds its last value when rd_ram_valid=0. Only the valid strobe is qualified.
- No backpressure: the requester may issue every cycle, and the responder never stalls after the reset-clear.

Decomposition:
- Package mem_pkg holds:
  - WORD_W=32 and BYTE_OFFSET_W=2
  - typedef mem_word_t
  - typedef mem_req_t, a struct {en, addr, data}
  - function is_aligned()
- One sub-module, rd_latency_pipe, is natural. It is a parameterised shift register of {valid, data} with RD_LATENCY stages, asynchronously cleared by reset.
- The storage array and the reset-clear counter stay in ram_responder.

Test Plan:
- Reset, INIT_ZERO=1, DEPTH_WORDS=16: release reset, wait 16 cycles, then read addr 0x3C -> rd_ram_valid one cycle later with data 0x0000_0000; no fault.
- Write 0xDEADBEEF to 0x10, then read 0x10 on the next edge -> wr_ram_ack pulse; read returns 0xDEADBEEF after RD_LATENCY; set RD_LATENCY=3 and verify a 3-cycle gap.
- Same edge: write 0x1234_5678 to 0x08, which holds 0xAAAA_AAAA, and read 0x08 -> read returns 0xAAAA_AAAA; a read one edge later returns 0x1234_5678.
- Read 0x06 (misaligned), then 0x40 with DEPTH_WORDS=16 (out of range) -> both slots give valid with 0x0 data; fault pulses twice; fault_addr ends at 0x40; storage unchanged.
- Back-to-back reads of 0x0, 0x4, 0x8, 0xC every cycle -> four consecutive valid cycles with data in order.
- Assert reset with two reads in flight (RD_LATENCY=2) -> no rd_ram_valid after reset; all outputs 0 immediately, asynchronously, without waiting for a clock edge.
